// File: rtl/dcim_shift_acc.sv
`default_nettype none
// ============================================================================
// Module   : dcim_shift_acc
// Brief    : MSB-first shift-and-add accumulator for bit-serial digital CIM.
//            Define DCIM_SACC_SIGNED_X_EN for a two's-complement activation.
// Revision : 1.0
// ============================================================================
module dcim_shift_acc #(
    parameter int W_WIDTH   = 12,
    parameter int X_BITS    = 8,
    parameter int ACC_WIDTH = W_WIDTH + X_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pp_valid,
    input  logic [W_WIDTH-1:0]   pp_n,
    output logic                 pp_ready,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data
);

    localparam int                 c_cnt_w = $clog2(X_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(X_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [W_WIDTH-1:0]   w_pp;
    logic [ACC_WIDTH-1:0] w_pp_ext;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic                 w_beat;

    // The OAI stage delivers the partial product inverted; weight is signed.
    assign w_pp     = ~pp_n;
    assign w_pp_ext = ACC_WIDTH'($signed(w_pp));
    assign w_beat   = (r_state == ST_ACC) && pp_valid;

`ifdef DCIM_SACC_SIGNED_X_EN
    // Activation MSB carries negative weight; acc is zero on the first beat.
    assign w_acc_nxt = (r_cnt == '0) ? (ACC_WIDTH'(0) - w_pp_ext)
                                     : ((r_acc << 1) + w_pp_ext);
`else
    assign w_acc_nxt = (r_acc << 1) + w_pp_ext;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)                     w_state_nxt = ST_ACC;
            ST_ACC:  if (w_beat && r_cnt == c_last) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)                 w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && start) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_beat) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    assign pp_ready  = (r_state == ST_ACC);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_dcim_shift_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcim_shift_acc
// Brief    : Directed self-checking bench for dcim_shift_acc.
// Revision : 1.0
// ============================================================================
module tb_dcim_shift_acc;

    localparam int W_WIDTH   = 12;
    localparam int X_BITS    = 8;
    localparam int ACC_WIDTH = 20;

`ifdef DCIM_SACC_SIGNED_X_EN
    localparam logic [ACC_WIDTH-1:0] EXP_W3X80   = 20'hFFE80;
    localparam logic [ACC_WIDTH-1:0] EXP_W800X80 = 20'h40000;
    localparam logic [ACC_WIDTH-1:0] EXP_W1XFF   = 20'hFFFFF;
`else
    localparam logic [ACC_WIDTH-1:0] EXP_W3X80   = 20'h00180;
    localparam logic [ACC_WIDTH-1:0] EXP_W800X80 = 20'hC0000;
    localparam logic [ACC_WIDTH-1:0] EXP_W1XFF   = 20'h000FF;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 pp_valid;
    logic [W_WIDTH-1:0]   pp_n;
    logic                 pp_ready;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    dcim_shift_acc #(
        .W_WIDTH   (W_WIDTH),
        .X_BITS    (X_BITS),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pp_valid  (pp_valid),
        .pp_n      (pp_n),
        .pp_ready  (pp_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; stall_after = beats accepted before a pp_valid gap.
    task automatic run_vec(input string tag, input logic [W_WIDTH-1:0] w,
                           input logic [X_BITS-1:0] x, input int stall_after,
                           input int stall_len, input int hold_ready,
                           input logic [ACC_WIDTH-1:0] exp_data, input bit chk_lat);
        int                   lat;
        logic [ACC_WIDTH-1:0] held;
        bit                   stable;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        check({tag, "_busy_acc"}, busy, 1);
        check({tag, "_ppready_acc"}, pp_ready, 1);
        for (int i = X_BITS - 1; i >= 0; i--) begin
            pp_valid = 1'b1;
            pp_n     = ~(w & {W_WIDTH{x[i]}});
            if (stall_len > 0 && i == X_BITS - 2) start = 1'b1;
            tick();
            lat++;
            start = 1'b0;
            if ((X_BITS - i) == stall_after) begin
                pp_valid = 1'b0;
                pp_n     = '0;
                repeat (stall_len) begin
                    tick();
                    lat++;
                end
            end
        end
        pp_valid = 1'b1;
        pp_n     = '0;
        out_ready = 1'b0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        if (chk_lat) check({tag, "_latency"}, lat, X_BITS + 1);
        check({tag, "_out_data"}, out_data, exp_data);
        check({tag, "_ppready_done"}, pp_ready, 0);
        held   = out_data;
        stable = 1'b1;
        repeat (hold_ready) begin
            if (stall_len > 0) start = 1'b1;
            tick();
            if (out_data !== held || !out_valid) stable = 1'b0;
        end
        if (hold_ready > 0) check({tag, "_done_stable"}, stable, 1);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_busy_after_hs"}, busy, 0);
        check({tag, "_valid_after_hs"}, out_valid, 0);
        tick();
        tick();
        pp_valid = 1'b0;
        check({tag, "_idle_hold"}, out_data, exp_data);
        check({tag, "_ppready_idle"}, pp_ready, 0);
    endtask

    initial begin
        int   seen_valid;
        logic [X_BITS-1:0] xr;
        rst_n     = 1'b0;
        start     = 1'b0;
        pp_valid  = 1'b0;
        pp_n      = '1;
        out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pp_ready", pp_ready, 0);
        rst_n = 1'b1;
        tick();

        run_vec("w3x05",   12'h003, 8'h05, 0, 0, 0, 20'h0000F,  1'b1);
        run_vec("w3x80",   12'h003, 8'h80, 0, 0, 0, EXP_W3X80,   1'b1);
        run_vec("w800x80", 12'h800, 8'h80, 0, 0, 0, EXP_W800X80, 1'b1);
        run_vec("w1xff",   12'h001, 8'hFF, 0, 0, 0, EXP_W1XFF,   1'b1);
        run_vec("wfffx05", 12'hFFF, 8'h05, 0, 0, 0, 20'hFFFFB,  1'b1);
        run_vec("stall",   12'h003, 8'h05, 2, 3, 4, 20'h0000F,  1'b0);

        // Reset in the middle of an accumulation must abandon it.
        xr    = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = X_BITS - 1; i >= X_BITS - 4; i--) begin
            pp_valid = 1'b1;
            pp_n     = ~(12'h003 & {W_WIDTH{xr[i]}});
            tick();
        end
        check("midrst_busy_before", busy, 1);
        rst_n    = 1'b0;
        pp_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pp_ready", pp_ready, 0);
        seen_valid = 0;
        repeat (12) begin
            tick();
            if (out_valid || busy) seen_valid++;
        end
        check("midrst_no_stale", seen_valid, 0);
        run_vec("w2x03", 12'h002, 8'h03, 0, 0, 0, 20'h00006, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
